// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive stage.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Small output FIFO with valid/ready pop side and sticky overrun on a dropped push.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_status,
    output logic             overrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             pop, full, push_ok, drop;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        full      = (count_q == FULL_CNT);
        pop       = (count_q != '0) && out_ready;
        push_ok   = push && (!full || pop);
        drop      = push && full && !pop;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A new drop in the same cycle as a clear keeps the flag set.
        overrun_d = drop | (overrun_q & ~clr_status);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset too because out_data must read 0 out of reset; fine at this depth.
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: state updates are non-blocking so every flop samples pre-edge values.
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign overrun   = overrun_q;

endmodule

// File: rtl/uart_rx_stage.sv
// 8N1 UART receiver: rx synchroniser, bit-timing FSM and stop-bit check, feeding byte_fifo.
module uart_rx_stage
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 clr_status,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rst_meta_q, rst_int_q;
    logic                 sync1_q, sync2_q, rx_s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 seen_high_q, seen_high_d;
    logic                 frame_err_q, frame_err_d;
    logic                 stop_sample, push;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_int_q  <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_int_q  <= rst_meta_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk or posedge rst_int_q) begin
        if (rst_int_q) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            seen_high_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            seen_high_q <= seen_high_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        seen_high_d = seen_high_q;
        case (state_q)
            IDLE: begin
                // A falling edge only counts once the line has been seen idle, so a held break cannot retrigger.
                if (rx_s) begin
                    seen_high_d = 1'b1;
                end else if (seen_high_q) begin
                    state_d     = START;
                    cnt_d       = '0;
                    seen_high_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    seen_high_d = rx_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        stop_sample = (state_q == STOP) && (cnt_q == CNT_LAST);
        push        = stop_sample && rx_s;
        frame_err_d = stop_sample && !rx_s;
    end

    assign frame_err = frame_err_q;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst_int_q),
        .push       (push),
        .push_data  (shreg_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clr_status (clr_status),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_uart_rx_stage.sv
// Self-checking bench for uart_rx_stage at 8 clocks per bit with a two-entry FIFO.
module tb_uart_rx_stage;

    localparam int CPB   = 8;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       out_ready = 1'b0;
    logic       clr_status = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, frame_err, overrun, busy;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] got_q[$];
    int         fe_cnt = 0;
    int         lat = 79;

    always #5 clk = ~clk;

    uart_rx_stage #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_status (clr_status),
        .busy       (busy)
    );

    // Every accepted byte and every frame_err cycle, observed mid-cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (frame_err) fe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        tick(3);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_data, frame_err, overrun, busy} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_outputs: got %03h expected 000", {out_valid, out_data, frame_err, overrun, busy});
        end
        rst = 1'b0;
        tick(6);
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL post_reset_idle: got %b expected 00", {out_valid, busy});
        end
    endtask

    task automatic test_latency();
        int n, fe0;
        logic seen, v2;
        logic [7:0] d;
        n = 0; seen = 1'b0; v2 = 1'b1; d = 8'h00;
        out_ready = 1'b1;
        got_q.delete();
        fe0 = fe_cnt;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (n < 200 && !seen) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        d = out_data;
                    end
                end
                @(posedge clk);
                @(negedge clk);
                v2 = out_valid;
            end
        join
        tick(4);
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL a5_timeout: got no out_valid within %0d cycles", n); end
        else lat = n;
        n_checks++;
        if (!(n >= 77 && n <= 79)) begin n_errors++; $display("FAIL a5_latency: got %0d expected 77..79", n); end
        n_checks++;
        if (d !== 8'hA5) begin n_errors++; $display("FAIL a5_data: got %02h expected a5", d); end
        n_checks++;
        if (v2 !== 1'b0) begin n_errors++; $display("FAIL a5_valid_one_cycle: got %b expected 0", v2); end
        n_checks++;
        if (got_q.size() != 1) begin n_errors++; $display("FAIL a5_count: got %0d expected 1", got_q.size()); end
        n_checks++;
        if (fe_cnt != fe0) begin n_errors++; $display("FAIL a5_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL a5_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_frame_err();
        int fe0;
        logic prev_busy, fe_seen, busy_ok;
        prev_busy = 1'b0; fe_seen = 1'b0; busy_ok = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        fe0 = fe_cnt;
        fork
            send_frame(8'h3C, 1'b0);
            repeat (100) begin
                @(negedge clk);
                if (frame_err && !fe_seen) begin
                    fe_seen = 1'b1;
                    busy_ok = !busy && prev_busy;
                end
                prev_busy = busy;
            end
        join
        tick(5);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin n_errors++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
        n_checks++;
        if (got_q.size() != 0) begin n_errors++; $display("FAIL ferr_delivered: got %0d bytes expected 0", got_q.size()); end
        n_checks++;
        if (busy_ok !== 1'b1) begin n_errors++; $display("FAIL ferr_busy_drop: got %b expected 1", busy_ok); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ferr_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        got_q.delete();
        send_frame(8'h11, 1'b1);
        tick(3);
        send_frame(8'h22, 1'b1);
        tick(3);
        n_checks++;
        if ({overrun, out_data} !== {1'b0, 8'h11}) begin
            n_errors++;
            $display("FAIL ovr_two_held: got ovr=%b head=%02h expected ovr=0 head=11", overrun, out_data);
        end
        send_frame(8'h33, 1'b1);
        tick(5);
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (out_data !== 8'h11) begin n_errors++; $display("FAIL ovr_head: got %02h expected 11", out_data); end
        n_checks++;
        if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        out_ready = 1'b1;
        tick(4);
        n_checks++;
        if (got_q.size() != 2) begin n_errors++; $display("FAIL ovr_pop_count: got %0d expected 2", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== 8'h11 || got_q[1] !== 8'h22) begin
                n_errors++;
                $display("FAIL ovr_pop_order: got %02h %02h expected 11 22", got_q[0], got_q[1]);
            end
        end
        n_checks++;
        if ({out_valid, overrun} !== 2'b01) begin n_errors++; $display("FAIL ovr_sticky: got %b expected 01", {out_valid, overrun}); end
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_glitch();
        int fe0;
        logic saw_busy;
        saw_busy = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        fe0 = fe_cnt;
        tick(2);
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        tick(1);
        n_checks++;
        if (saw_busy !== 1'b1) begin n_errors++; $display("FAIL glitch_started: got %b expected 1", saw_busy); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_idle: got %b expected 0", busy); end
        n_checks++;
        if (got_q.size() != 0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_output: got %0d bytes valid=%b expected 0 bytes valid=0", got_q.size(), out_valid);
        end
        n_checks++;
        if (fe_cnt != fe0) begin n_errors++; $display("FAIL glitch_ferr: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_reset_mid();
        int fe0;
        logic busy_before;
        logic [11:0] during;
        busy_before = 1'b0;
        during = 12'hfff;
        out_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        tick(3);
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_pending: got %b expected 1", out_valid); end
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(CPB * 5 + 4);
                busy_before = busy;
                rst = 1'b1;
                @(negedge clk);
                during = {out_valid, out_data, frame_err, overrun, busy};
                tick(3);
                rst = 1'b0;
            end
        join
        tick(10);
        got_q.delete();
        fe0 = fe_cnt;
        out_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        tick(10);
        n_checks++;
        if (busy_before !== 1'b1) begin n_errors++; $display("FAIL rmid_in_frame: got %b expected 1", busy_before); end
        n_checks++;
        if (during !== 12'h000) begin n_errors++; $display("FAIL rmid_outputs: got %03h expected 000", during); end
        n_checks++;
        if (got_q.size() != 1) begin n_errors++; $display("FAIL rmid_count: got %0d expected 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== 8'h5A) begin n_errors++; $display("FAIL rmid_data: got %02h expected 5a", got_q[0]); end
        end
        n_checks++;
        if (fe_cnt != fe0) begin n_errors++; $display("FAIL rmid_ferr: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_break();
        int fe0;
        logic [7:0] b;
        b = 8'($urandom);
        out_ready = 1'b1;
        got_q.delete();
        fe0 = fe_cnt;
        rx = 1'b0;
        tick(CPB * 20);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin n_errors++; $display("FAIL break_ferr: got %0d pulses expected 1", fe_cnt - fe0); end
        n_checks++;
        if (busy !== 1'b0 || got_q.size() != 0) begin
            n_errors++;
            $display("FAIL break_wait: got busy=%b bytes=%0d expected busy=0 bytes=0", busy, got_q.size());
        end
        rx = 1'b1;
        tick(10);
        send_frame(b, 1'b1);
        tick(10);
        n_checks++;
        if (got_q.size() != 1) begin n_errors++; $display("FAIL break_rearm_count: got %0d expected 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== b) begin n_errors++; $display("FAIL break_rearm_data: got %02h expected %02h", got_q[0], b); end
        end
        n_checks++;
        if (fe_cnt - fe0 != 1) begin n_errors++; $display("FAIL break_single: got %0d pulses expected 1", fe_cnt - fe0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b1;
        logic [7:0] exp_q[$];
        b1 = 8'($urandom);
        exp_q = '{b1, 8'h00, 8'hFF};
        out_ready = 1'b0;
        got_q.delete();
        send_frame(b1, 1'b1);
        tick(4);
        send_frame(8'h00, 1'b1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(lat - 1);
                out_ready = 1'b1;
                tick(1);
                out_ready = 1'b0;
            end
        join
        tick(4);
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h00}) begin
            n_errors++;
            $display("FAIL b2b_head: got valid=%b data=%02h expected valid=1 data=00", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick(5);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL b2b_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    // Reference: good frames arrive in send order, bad-stop frames only bump the error count.
    task automatic test_random();
        logic [7:0] exp_q[$];
        int exp_fe, fe0;
        logic done;
        exp_fe = 0;
        done = 1'b0;
        got_q.delete();
        fe0 = fe_cnt;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    logic [7:0] b;
                    logic good;
                    b = 8'($urandom);
                    good = ($urandom_range(0, 4) != 0);
                    if (good) exp_q.push_back(b);
                    else exp_fe++;
                    send_frame(b, good);
                    tick(good ? $urandom_range(0, 5) : $urandom_range(2, 5));
                end
                done = 1'b1;
            end
            while (!done) begin
                out_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
        join
        out_ready = 1'b1;
        tick(10);
        n_checks++;
        if (fe_cnt - fe0 != exp_fe) begin n_errors++; $display("FAIL rand_ferr: got %0d expected %0d", fe_cnt - fe0, exp_fe); end
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL rand_overrun: got %b expected 0", overrun); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL rand_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_break();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
